axi4_lite_regfile_slave: RTL and testbench
==========================================

AXI4_LITE_REGFILE_SLAVE -- requirements
Module: axi4_lite_regfile_slave

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, byte-address width of the AW/AR channels.
REQ-002 Parameter DATA_WIDTH, default 32, data width; fixed at 32 (WSTRB is 4 bits).
REQ-003 Parameter NUM_REGS, default 16, number of 32-bit registers; power of 2, 2..256.
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 resetn  in  1  asynchronous, active-low reset.
REQ-006 AW_ADDR  in  ADDR_WIDTH  write address.
REQ-007 AW_VALID  in  1  write address valid.
REQ-008 AW_READY  out  1  write address accepted.
REQ-009 W_DATA  in  DATA_WIDTH  write data.
REQ-010 WSTRB  in  4  byte enables for W_DATA.
REQ-011 W_VALID  in  1  write data valid.
REQ-012 W_READY  out  1  write data accepted.
REQ-013 B_RESP  out  2  write response (00 OKAY, 10 SLVERR).
REQ-014 B_VALID  out  1  write response valid.
REQ-015 B_READY  in  1  master accepts write response.
REQ-016 AR_ADDR  in  ADDR_WIDTH  read address.
REQ-017 AR_VALID  in  1  read address valid.
REQ-018 AR_READY  out  1  read address accepted.
REQ-019 R_DATA  out  DATA_WIDTH  read data.
REQ-020 R_RESP  out  2  read response (00 OKAY, 10 SLVERR).
REQ-021 R_VALID  out  1  read data valid.
REQ-022 R_READY  in  1  master accepts read data.

Function
REQ-023 Register index SHALL be addr[log2(NUM_REGS)+1:2]; addr[1:0] ignored; address in range iff addr < NUM_REGS*4.
REQ-024 Write FSM states: W_IDLE, W_RESP; AW and W channels captured independently in W_IDLE.
REQ-025 In W_IDLE, AW_READY=1 until AW captured, W_READY=1 until W captured; each captured on its own VALID&READY edge, in either order or same cycle.
REQ-026 On the edge where the second of AW/W is captured: in-range register updated per WSTRB byte lane (strobe 0 keeps old byte), FSM -> W_RESP, B_VALID=1 from the next cycle.
REQ-027 In W_RESP: AW_READY=W_READY=0; B_VALID/B_RESP held stable until B_READY; on B_VALID&B_READY -> W_IDLE, capture flags cleared.
REQ-028 Read FSM states: R_IDLE (AR_READY=1), R_DATA (AR_READY=0, R_VALID=1).
REQ-029 On AR_VALID&AR_READY: register contents sampled into R_DATA, R_RESP set, -> R_DATA; R_VALID=1 from the next cycle (1-cycle latency).
REQ-030 R_DATA/R_RESP held stable until R_VALID&R_READY, then -> R_IDLE; a new AR accepted the following cycle at earliest.
REQ-031 Read and write FSMs independent; same-register read sampled on the same edge as a write commit returns the pre-write value.
REQ-032 VALID outputs never depend combinationally on READY inputs; all outputs registered.

Reset
REQ-033 resetn=0 SHALL asynchronously force: all registers 0, both FSMs idle, capture flags cleared, AW_READY=W_READY=AR_READY=0, B_VALID=R_VALID=0, B_RESP=R_RESP=00, R_DATA=0.
REQ-034 Ready outputs go to 1 on the first rising edge after resetn deasserts; reset mid-transaction drops it with no response.

Configuration
REQ-035 Macro AXI_REGFILE_SLVERR_EN defined: out-of-range write discarded with B_RESP=10; out-of-range read returns R_DATA=0, R_RESP=10.
REQ-036 Macro undefined: out-of-range write discarded with B_RESP=00; read returns R_DATA=0, R_RESP=00.

Verification
REQ-037 AW=0x08 and W=0xDEADBEEF, WSTRB=F same cycle; then AR=0x08 -> B_VALID one cycle later, B_RESP=00; R_DATA=0xDEADBEEF, R_RESP=00.
REQ-038 W (0x11223344, WSTRB=0101) three cycles before AW=0x04 on reg holding 0xAABBCCDD -> W_READY drops after W capture; readback 0xAA22CC44.
REQ-039 B_READY held 0 for 5 cycles -> B_VALID/B_RESP stable, AW_READY=W_READY=0 throughout; next write accepted only after handshake.
REQ-040 AR=0x40 with NUM_REGS=16 -> R_DATA=0, R_RESP=10 with AXI_REGFILE_SLVERR_EN, 00 without; write to 0x40 changes no register.
REQ-041 AR=0x0C on same edge as write commit of 0x55 to 0x0C (old 0x33) -> R_DATA=0x33; next read 0x55.
REQ-042 resetn pulsed low while R_VALID=1 and B_VALID=1 -> both 0 immediately; all registers read 0 afterwards.

Source files
------------

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite slave that exposes NUM_REGS 32-bit registers and supports byte-strobed writes.
// Define AXI_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR instead of OKAY.
module axi4_lite_regfile_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic [ADDR_WIDTH-1:0] AW_ADDR,
  input  logic                  AW_VALID,
  output logic                  AW_READY,
  input  logic [DATA_WIDTH-1:0] W_DATA,
  input  logic [3:0]            WSTRB,
  input  logic                  W_VALID,
  output logic                  W_READY,
  output logic [1:0]            B_RESP,
  output logic                  B_VALID,
  input  logic                  B_READY,
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]            R_RESP,
  output logic                  R_VALID,
  input  logic                  R_READY
);

  localparam int IDX_W = $clog2(NUM_REGS);

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_BUSY = 1'b1;

`ifdef AXI_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR_RESP = 2'b10;
`else
  localparam logic [1:0] OOR_RESP = 2'b00;
`endif

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic [0:0]            w_state_reg;
  logic [0:0]            r_state_reg;
  logic                  aw_done_reg;
  logic                  w_done_reg;
  logic [ADDR_WIDTH-1:0] aw_addr_reg;
  logic [DATA_WIDTH-1:0] w_data_reg;
  logic [3:0]            wstrb_reg;

  logic                  aw_hs, w_hs, ar_hs;
  logic                  aw_have, w_have, wr_commit;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [3:0]            wr_strb;
  logic                  wr_in_range, rd_in_range;
  logic [IDX_W-1:0]      wr_idx, rd_idx;
  logic [NUM_REGS-1:0]   reg_we;

  assign aw_hs = AW_VALID & AW_READY;
  assign w_hs  = W_VALID & W_READY;
  assign ar_hs = AR_VALID & AR_READY;

  // The commit uses whichever half arrives this cycle directly, so AW and W may land in any order.
  assign aw_have   = aw_done_reg | aw_hs;
  assign w_have    = w_done_reg | w_hs;
  assign wr_commit = aw_have & w_have & (aw_hs | w_hs);
  assign wr_addr   = aw_hs ? AW_ADDR : aw_addr_reg;
  assign wr_data   = w_hs ? W_DATA : w_data_reg;
  assign wr_strb   = w_hs ? WSTRB : wstrb_reg;

  assign wr_in_range = ((wr_addr >> (IDX_W + 2)) == '0);
  assign rd_in_range = ((AR_ADDR >> (IDX_W + 2)) == '0);
  assign wr_idx      = wr_addr[IDX_W+1:2];
  assign rd_idx      = AR_ADDR[IDX_W+1:2];

  generate
    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_we
      assign reg_we[gi] = wr_commit & wr_in_range & (wr_idx == IDX_W'(gi));
    end
  endgenerate

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        for (int b = 0; b < 4; b++) begin
          if (reg_we[i] && wr_strb[b]) regs[i][8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      w_state_reg <= W_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      aw_addr_reg <= '0;
      w_data_reg  <= '0;
      wstrb_reg   <= '0;
      AW_READY    <= 1'b0;
      W_READY     <= 1'b0;
      B_VALID     <= 1'b0;
      B_RESP      <= 2'b00;
    end else if (w_state_reg == W_IDLE) begin
      if (aw_hs) begin
        aw_done_reg <= 1'b1;
        aw_addr_reg <= AW_ADDR;
      end
      if (w_hs) begin
        w_done_reg <= 1'b1;
        w_data_reg <= W_DATA;
        wstrb_reg  <= WSTRB;
      end
      if (wr_commit) begin
        w_state_reg <= W_RESP;
        AW_READY    <= 1'b0;
        W_READY     <= 1'b0;
        B_VALID     <= 1'b1;
        B_RESP      <= wr_in_range ? 2'b00 : OOR_RESP;
      end else begin
        AW_READY <= ~aw_have;
        W_READY  <= ~w_have;
      end
    end else if (B_VALID && B_READY) begin
      w_state_reg <= W_IDLE;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      B_VALID     <= 1'b0;
      AW_READY    <= 1'b1;
      W_READY     <= 1'b1;
    end
  end

  // Read data is sampled on the AR edge, so a same-edge write commit is not visible yet.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state_reg <= R_IDLE;
      AR_READY    <= 1'b0;
      R_VALID     <= 1'b0;
      R_DATA      <= '0;
      R_RESP      <= 2'b00;
    end else if (r_state_reg == R_IDLE) begin
      if (ar_hs) begin
        r_state_reg <= R_BUSY;
        AR_READY    <= 1'b0;
        R_VALID     <= 1'b1;
        R_DATA      <= rd_in_range ? regs[rd_idx] : '0;
        R_RESP      <= rd_in_range ? 2'b00 : OOR_RESP;
      end else begin
        AR_READY <= 1'b1;
      end
    end else if (R_VALID && R_READY) begin
      r_state_reg <= R_IDLE;
      R_VALID     <= 1'b0;
      AR_READY    <= 1'b1;
    end
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Directed bench for axi4_lite_regfile_slave with scoreboard queues for B and R responses.
module tb_axi4_lite_regfile_slave;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic [31:0] AW_ADDR = '0;
  logic        AW_VALID = 1'b0;
  logic        AW_READY;
  logic [31:0] W_DATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        W_VALID = 1'b0;
  logic        W_READY;
  logic [1:0]  B_RESP;
  logic        B_VALID;
  logic        B_READY = 1'b0;
  logic [31:0] AR_ADDR = '0;
  logic        AR_VALID = 1'b0;
  logic        AR_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_VALID;
  logic        R_READY = 1'b0;

  always #5 clk = ~clk;

  axi4_lite_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .clk(clk), .resetn(resetn),
    .AW_ADDR(AW_ADDR), .AW_VALID(AW_VALID), .AW_READY(AW_READY),
    .W_DATA(W_DATA), .WSTRB(WSTRB), .W_VALID(W_VALID), .W_READY(W_READY),
    .B_RESP(B_RESP), .B_VALID(B_VALID), .B_READY(B_READY),
    .AR_ADDR(AR_ADDR), .AR_VALID(AR_VALID), .AR_READY(AR_READY),
    .R_DATA(R_DATA), .R_RESP(R_RESP), .R_VALID(R_VALID), .R_READY(R_READY)
  );

`ifdef AXI_REGFILE_SLVERR_EN
  localparam logic [1:0] OOR = 2'b10;
`else
  localparam logic [1:0] OOR = 2'b00;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] model [16];
  logic [33:0] rd_q [$];
  logic [1:0]  wr_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    if (addr < 32'd64) begin
      model[addr[5:2]] = merge(model[addr[5:2]], data, strb);
      wr_q.push_back(2'b00);
    end else begin
      wr_q.push_back(OOR);
    end
  endtask

  task automatic push_read(input logic [31:0] addr);
    if (addr < 32'd64) rd_q.push_back({2'b00, model[addr[5:2]]});
    else rd_q.push_back({OOR, 32'h0});
  endtask

  task automatic send_aw_w(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           input string tag);
    int   cyc;
    logic aw_f, w_f;
    AW_ADDR = addr; W_DATA = data; WSTRB = strb;
    AW_VALID = 1'b1; W_VALID = 1'b1;
    cyc = 0;
    while ((AW_VALID || W_VALID) && cyc < 20) begin
      aw_f = AW_VALID & AW_READY;
      w_f  = W_VALID & W_READY;
      tick();
      cyc++;
      if (aw_f) AW_VALID = 1'b0;
      if (w_f) W_VALID = 1'b0;
    end
    check({tag, "_aw_w_accept"}, 64'({AW_VALID, W_VALID}), 64'(0));
    AW_VALID = 1'b0; W_VALID = 1'b0;
  endtask

  task automatic collect_b(input int hold, input string tag);
    int         cyc;
    logic [1:0] exp_resp;
    cyc = 0;
    while (!B_VALID && cyc < 20) begin tick(); cyc++; end
    check({tag, "_bvalid"}, 64'(B_VALID), 64'(1));
    exp_resp = (wr_q.size() > 0) ? wr_q.pop_front() : 2'bxx;
    check({tag, "_bresp"}, 64'(B_RESP), 64'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_bhold"}, 64'({B_VALID, B_RESP, AW_READY, W_READY}), 64'({1'b1, exp_resp, 2'b00}));
    end
    B_READY = 1'b1;
    tick();
    B_READY = 1'b0;
    check({tag, "_bdone"}, 64'(B_VALID), 64'(0));
  endtask

  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int hold, input string tag);
    model_write(addr, data, strb);
    send_aw_w(addr, data, strb, tag);
    check({tag, "_blatency"}, 64'(B_VALID), 64'(1));
    collect_b(hold, tag);
  endtask

  task automatic send_ar(input logic [31:0] addr, input string tag);
    int cyc;
    push_read(addr);
    AR_ADDR = addr;
    AR_VALID = 1'b1;
    cyc = 0;
    while (!AR_READY && cyc < 20) begin tick(); cyc++; end
    check({tag, "_arready"}, 64'(AR_READY), 64'(1));
    tick();
    AR_VALID = 1'b0;
    check({tag, "_rlatency"}, 64'(R_VALID), 64'(1));
  endtask

  task automatic collect_r(input string tag);
    int          cyc;
    logic [33:0] exp_r;
    cyc = 0;
    while (!R_VALID && cyc < 20) begin tick(); cyc++; end
    exp_r = (rd_q.size() > 0) ? rd_q.pop_front() : 34'bx;
    check({tag, "_rdata"}, 64'({R_RESP, R_DATA}), 64'(exp_r));
    R_READY = 1'b1;
    tick();
    R_READY = 1'b0;
    check({tag, "_rdone"}, 64'({R_VALID, AR_READY}), 64'(2'b01));
  endtask

  task automatic do_read(input logic [31:0] addr, input string tag);
    send_ar(addr, tag);
    collect_r(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish within 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [3:0]  s;
    for (int i = 0; i < 16; i++) model[i] = '0;

    // Reset state and first-edge ready behaviour
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", 64'({AW_READY, W_READY, AR_READY, B_VALID, R_VALID, B_RESP, R_RESP, R_DATA}), 64'(0));
    @(negedge clk);
    resetn = 1'b1;
    #1;
    check("ready_before_edge", 64'({AW_READY, W_READY, AR_READY}), 64'(0));
    tick();
    check("ready_after_edge", 64'({AW_READY, W_READY, AR_READY}), 64'(3'b111));

    // Same-cycle AW/W then readback
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, "basic_wr");
    do_read(32'h08, "basic_rd");

    // W three cycles ahead of AW, partial strobes
    do_write(32'h04, 32'hAABBCCDD, 4'hF, 0, "pre_wr");
    model_write(32'h04, 32'h11223344, 4'b0101);
    W_DATA = 32'h11223344; WSTRB = 4'b0101; W_VALID = 1'b1;
    check("early_w_ready", 64'(W_READY), 64'(1));
    tick();
    W_VALID = 1'b0;
    check("early_w_captured", 64'({W_READY, AW_READY, B_VALID}), 64'(3'b010));
    repeat (2) begin
      tick();
      check("early_w_wait", 64'({W_READY, AW_READY, B_VALID}), 64'(3'b010));
    end
    AW_ADDR = 32'h04; AW_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0;
    check("late_aw_blatency", 64'(B_VALID), 64'(1));
    collect_b(0, "late_aw");
    rd_q.push_back({2'b00, 32'hAA22CC44});
    AR_ADDR = 32'h04; AR_VALID = 1'b1;
    tick();
    AR_VALID = 1'b0;
    collect_r("strobe_rd");

    // Back-pressure on B
    do_write(32'h10, 32'h0BADF00D, 4'hF, 5, "bhold_wr");
    do_read(32'h10, "bhold_rd");

    // Out-of-range read and write
    do_read(32'h40, "oor_rd");
    do_write(32'h40, 32'hFFFFFFFF, 4'hF, 0, "oor_wr");

    // Varied patterns in every register, then full readback
    for (int i = 0; i < 16; i++) begin
      d = $urandom;
      s = 4'($urandom_range(15, 0));
      do_write(32'(i * 4), d, s, i % 3, "pat_wr");
    end
    for (int i = 0; i < 16; i++) do_read(32'(i * 4), "pat_rd");

    // Read sampled on the same edge as a write commit
    do_write(32'h0C, 32'h33, 4'hF, 0, "rw_pre");
    push_read(32'h0C);
    model_write(32'h0C, 32'h55, 4'hF);
    AW_ADDR = 32'h0C; W_DATA = 32'h55; WSTRB = 4'hF; AR_ADDR = 32'h0C;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
    check("rw_readys", 64'({AW_READY, W_READY, AR_READY}), 64'(3'b111));
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    check("rw_valids", 64'({B_VALID, R_VALID}), 64'(2'b11));
    collect_r("rw_old");
    collect_b(0, "rw_b");
    do_read(32'h0C, "rw_new");

    // Reset with both responses outstanding
    AW_ADDR = 32'h14; W_DATA = 32'h12345678; WSTRB = 4'hF; AR_ADDR = 32'h0C;
    AW_VALID = 1'b1; W_VALID = 1'b1; AR_VALID = 1'b1;
    tick();
    AW_VALID = 1'b0; W_VALID = 1'b0; AR_VALID = 1'b0;
    check("rst_pending", 64'({B_VALID, R_VALID}), 64'(2'b11));
    #3;
    resetn = 1'b0;
    #1;
    check("rst_async", 64'({B_VALID, R_VALID, AW_READY, W_READY, AR_READY, B_RESP, R_RESP, R_DATA}), 64'(0));
    @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = '0;
    tick();
    check("rst_ready", 64'({AW_READY, W_READY, AR_READY, B_VALID, R_VALID}), 64'(5'b11100));
    for (int i = 0; i < 16; i++) do_read(32'(i * 4), "rst_rd");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
